// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Default constants describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int unsigned DefClkDiv  = 2;
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefCntW    = 10;

  function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // True while cnt lies inside the sync pulse, which starts right after the front porch.
  function automatic logic in_sync_window(int unsigned cnt, int unsigned active,
                                          int unsigned fp, int unsigned sync);
    return (cnt >= active + fp) && (cnt < active + fp + sync);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping counter plus registered
// sync/active decode taken from the next-state count so it aligns with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DefHActive,
  parameter int unsigned FP     = DefHFp,
  parameter int unsigned SYNC   = DefHSync,
  parameter int unsigned BP     = DefHBp,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam int unsigned Total = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] Last = CNT_W'(Total - 1);

  if (ACTIVE < 1) begin : g_bad_active
    $error("vga_axis_counter: ACTIVE must be >= 1");
  end
  if (SYNC < 1) begin : g_bad_sync
    $error("vga_axis_counter: SYNC must be >= 1");
  end
  if ((CNT_W < 1) || ((CNT_W < 32) && (((Total - 1) >> CNT_W) != 0))) begin : g_bad_width
    $error("vga_axis_counter: CNT_W cannot hold the axis total");
  end

  logic [CNT_W-1:0] count_d, count_q;
  logic             sync_q, active_q;

  always_comb begin
    wrap    = advance && (count_q == Last);
    count_d = count_q;
    if (advance) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      sync_q   <= ~POL;
      active_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_q   <= in_sync_window(32'(count_d), ACTIVE, FP, SYNC) ? POL : ~POL;
      active_q <= 32'(count_d) < ACTIVE;
    end
  end

  assign count  = count_q;
  assign sync   = sync_q;
  assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator driven by a pixel clock-enable.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned H_ACTIVE  = DefHActive,
  parameter int unsigned H_FP      = DefHFp,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BP      = DefHBp,
  parameter int unsigned V_ACTIVE  = DefVActive,
  parameter int unsigned V_FP      = DefVFp,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BP      = DefVBp,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_pix_ce,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [CNT_W-1:0] o_x_pixel,
  output logic [CNT_W-1:0] o_y_pixel,
  output logic             o_drawing,
  output logic             o_line_start,
  output logic             o_frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic             o_vblank,
  output logic [15:0]      o_frame_count
`else
  output logic             o_vblank
`endif
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q;
  logic            pix_ce;
  logic            h_wrap, v_wrap;
  logic            h_active, v_active;
  logic            line_start_q, frame_start_q;

  // With CLK_DIV=1 DivLast is 0, so the enable stays high permanently.
  assign pix_ce = (div_q == DivLast);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= pix_ce ? '0 : div_q + DivW'(1);
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk     (i_clk),
    .reset   (i_reset),
    .advance (pix_ce),
    .count   (o_x_pixel),
    .wrap    (h_wrap),
    .sync    (o_hsync),
    .active  (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk     (i_clk),
    .reset   (i_reset),
    .advance (h_wrap),
    .count   (o_y_pixel),
    .wrap    (v_wrap),
    .sync    (o_vsync),
    .active  (v_active)
  );

  assign o_pix_ce      = pix_ce;
  assign o_drawing     = h_active & v_active;
  assign o_vblank      = ~v_active;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_cnt_q <= '0;
    end else if (h_wrap & v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small modes, a mid-frame reset,
// and hand-computed strobe periods.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic        drawing;
    logic        line_start;
    logic        frame_start;
    logic        vblank;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int unsigned k;
    obs_t        o;
  } item_t;

  typedef struct {
    int unsigned d, ha, hf, hs, hb, va, vf, vs, vb;
    bit          hpol, vpol;
  } mode_t;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FcEn = 1'b1;
`else
  localparam bit FcEn = 1'b0;
`endif

  logic clk;
  logic reset;

  logic       a_pix_ce, a_hsync, a_vsync, a_drawing, a_line_start, a_frame_start, a_vblank;
  logic       b_pix_ce, b_hsync, b_vsync, b_drawing, b_line_start, b_frame_start, b_vblank;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic [15:0] a_fc, b_fc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode A: CLK_DIV=1, 14-clk line, 7 lines, positive syncs.
  vga_timing_gen #(
    .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CNT_W (10)
  ) u_dut_a (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_pix_ce      (a_pix_ce),
    .o_hsync       (a_hsync),
    .o_vsync       (a_vsync),
    .o_x_pixel     (a_x),
    .o_y_pixel     (a_y),
    .o_drawing     (a_drawing),
    .o_line_start  (a_line_start),
    .o_frame_start (a_frame_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .o_vblank      (a_vblank),
    .o_frame_count (a_fc)
`else
    .o_vblank      (a_vblank)
`endif
  );

  // Mode B: CLK_DIV=3, 10 pixels x 6 lines, negative syncs -> 30-clk line, 180-clk frame.
  vga_timing_gen #(
    .CLK_DIV (3), .H_ACTIVE (6), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .CNT_W (10)
  ) u_dut_b (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_pix_ce      (b_pix_ce),
    .o_hsync       (b_hsync),
    .o_vsync       (b_vsync),
    .o_x_pixel     (b_x),
    .o_y_pixel     (b_y),
    .o_drawing     (b_drawing),
    .o_line_start  (b_line_start),
    .o_frame_start (b_frame_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .o_vblank      (b_vblank),
    .o_frame_count (b_fc)
`else
    .o_vblank      (b_vblank)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign a_fc = '0;
  assign b_fc = '0;
`endif

  obs_t obs_a, obs_b;
  assign obs_a = {a_pix_ce, a_hsync, a_vsync, a_drawing, a_line_start, a_frame_start,
                  a_vblank, a_x, a_y, a_fc};
  assign obs_b = {b_pix_ce, b_hsync, b_vsync, b_drawing, b_line_start, b_frame_start,
                  b_vblank, b_x, b_y, b_fc};

  int    checks   = 0;
  int    failures = 0;
  item_t qa[$];
  item_t qb[$];

  // Expected outputs k edges after the reset edge: pixels advance on every edge with
  // k a multiple of d, so p = k/d pixel steps have elapsed.
  function automatic obs_t model(mode_t m, int unsigned k);
    int unsigned ht, vt, p, h, v;
    obs_t o;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    p  = k / m.d;
    h  = p % ht;
    v  = (p / ht) % vt;
    o.pix_ce      = (k % m.d) == (m.d - 1);
    o.hsync       = (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) ? m.hpol : !m.hpol;
    o.vsync       = (v >= m.va + m.vf && v < m.va + m.vf + m.vs) ? m.vpol : !m.vpol;
    o.drawing     = (h < m.ha) && (v < m.va);
    o.line_start  = (k > 0) && (k % m.d == 0) && (h == 0);
    o.frame_start = o.line_start && (v == 0);
    o.vblank      = v >= m.va;
    o.x           = 10'(h);
    o.y           = 10'(v);
    o.fc          = FcEn ? 16'(p / (ht * vt)) : 16'd0;
    return o;
  endfunction

  task automatic compare(string name, item_t it, obs_t act);
    checks++;
    if (act !== it.o) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h (x=%0d y=%0d) required=%h (x=%0d y=%0d)",
               name, it.k, act, act.x, act.y, it.o, it.o.x, it.o.y);
    end
  endtask

  task automatic check_int(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per instance per cycle, plus strobe period tracking.
  int cyc = 0;
  int last_al = -1, last_af = -1, last_bl = -1, last_bf = -1;
  int nf_a = 0, nf_b = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        last_al = -1; last_af = -1; last_bl = -1; last_bf = -1;
      end
      if (qa.size() > 0) compare("mode_a", qa.pop_front(), obs_a);
      if (qb.size() > 0) compare("mode_b", qb.pop_front(), obs_b);
      if (a_line_start) begin
        if (last_al >= 0) check_int("a_line_period", cyc - last_al, 14);
        last_al = cyc;
      end
      if (a_frame_start) begin
        nf_a++;
        if (last_af >= 0) check_int("a_frame_period", cyc - last_af, 98);
        last_af = cyc;
      end
      if (b_line_start) begin
        if (last_bl >= 0) check_int("b_line_period", cyc - last_bl, 30);
        last_bl = cyc;
      end
      if (b_frame_start) begin
        nf_b++;
        if (last_bf >= 0) check_int("b_frame_period", cyc - last_bf, 180);
        last_bf = cyc;
      end
    end
  end

  // Stimulus: sets reset for the coming edge and queues the state expected after it.
  mode_t       ma, mb;
  int unsigned k;

  task automatic step(bit rst);
    reset = rst;
    k = rst ? 0 : k + 1;
    qa.push_back('{k: k, o: model(ma, k)});
    qb.push_back('{k: k, o: model(mb, k)});
    @(negedge clk);
  endtask

  initial begin
    ma = '{d: 1, ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 1, vs: 1, vb: 1, hpol: 1'b1, vpol: 1'b1};
    mb = '{d: 3, ha: 6, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1, hpol: 1'b0, vpol: 1'b0};
    k  = 0;
    repeat (3) step(1'b1);
    repeat (250) step(1'b0);
    // Single-cycle reset mid-frame (A at h=12,v=3; B at h=3,v=2).
    step(1'b1);
    repeat (600) step(1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_int("queue_a_drained", qa.size(), 0);
    check_int("queue_b_drained", qb.size(), 0);
    // A: frames at k=98,196 before the mid reset and 98..588 after; B: 180, then 180/360/540.
    check_int("a_frame_starts", nf_a, 8);
    check_int("b_frame_starts", nf_b, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA core. Generates pixel-clock enable, horizontal/vertical counters, sync pulses, active-area flag and X/Y coordinates for any VESA-style mode.
- Runs from a single system clock and uses a clock-enable rather than a divided clock.
- Sits between the board clock and the pixel/framebuffer logic. Feeds the DAC/sync pins and the draw pipeline.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- HSYNC_POL, 0, asserted level of o_hsync.
- VSYNC_POL, 0, asserted level of o_vsync.
- CNT_W, 10, counter/coordinate width. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- i_clk  in  1  system clock (50 MHz in current board)
- i_reset  in  1  synchronous, active-high reset
- o_pix_ce  out  1  pixel clock enable, one i_clk cycle every CLK_DIV
- o_hsync  out  1  horizontal sync, polarity per HSYNC_POL
- o_vsync  out  1  vertical sync, polarity per VSYNC_POL
- o_x_pixel  out  CNT_W  current horizontal count
- o_y_pixel  out  CNT_W  current vertical count
- o_drawing  out  1  high while h<H_ACTIVE and v<V_ACTIVE
- o_line_start  out  1  one-i_clk strobe on entry to h=0
- o_frame_start  out  1  one-i_clk strobe on entry to (0,0)
- o_vblank  out  1  high while v>=V_ACTIVE

Behaviour:
- Single clock i_clk. Reset is synchronous and active-high on i_reset. All state is updated on the rising edge of i_clk.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL defined likewise.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - o_pix_ce = (div_cnt==CLK_DIV-1), decoded from the register.
  - CLK_DIV=1: o_pix_ce is constantly 1 outside reset.
- Counters:
  - On an edge with o_pix_ce=1, h increments. At H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps V_TOTAL-1 -> 0 when h wraps.
  - Counters are held when o_pix_ce=0.
- Decode (registered, computed from next-state counters so all outputs align with o_x_pixel/o_y_pixel in the same cycle):
  - hsync asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Deasserted level is the inverse of *_POL.
- Strobes:
  - o_line_start is 1 for exactly the one i_clk cycle after the edge where h wrapped to 0.
  - o_frame_start is 1 for the cycle after the edge where both h and v wrapped.
  - Both strobes are 0 at all other times.
- Coordinates: o_x_pixel/o_y_pixel carry raw counts, including blanking. Consumers qualify with o_drawing.
- Reset values: div_cnt=0, h=0, v=0, o_x_pixel=0, o_y_pixel=0, o_drawing=1, o_hsync=~HSYNC_POL, o_vsync=~VSYNC_POL, o_vblank=0, o_line_start=0, o_frame_start=0, o_pix_ce=0 (CLK_DIV>1) or 1 (CLK_DIV=1).
- Reset mid-line or mid-frame: next edge forces the reset state. There is no strobe on reset exit. The first o_frame_start occurs after one full frame.
- Parameter legality: out-of-range values (CNT_W too small, CLK_DIV=0, any porch/sync = 0 where illegal) are rejected at elaboration.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output o_frame_count [15:0].
  - Reset 0.
  - Increments on the same edge that raises o_frame_start.
  - Wraps 65535 -> 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants.
  - H_TOTAL/V_TOTAL helper functions.
  - A sync window decode function.
- Sub-module vga_axis_counter: one instance per axis. Each instance provides:
  - Parametrised by active/FP/sync/BP/polarity.
  - Inputs: advance enable, synchronous reset.
  - Outputs: count, wrap strobe, sync level, active flag.
  - The vertical instance is advanced by (o_pix_ce & horizontal wrap).

Test Plan:
- Defaults, release reset, run 2 frames -> o_pix_ce every 2nd clk. 800 pix_ce per line, 525 lines per frame, o_frame_start period 840000 clks.
- Defaults -> o_hsync low exactly for h=656..751. o_vsync low exactly for v=490..491. o_drawing high only for h<640 and v<480.
- CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HSYNC_POL=VSYNC_POL=1 -> line 14 clks, frame 98 clks, hsync high at h=10..11, o_pix_ce constant 1.
- Assert i_reset for 1 clk at h=300,v=200 -> next cycle h=0, v=0, syncs inactive, no o_line_start/o_frame_start until the next wrap.
- Strobe check -> o_line_start is a 1-clk pulse coinciding with o_x_pixel=0. o_frame_start coincides with o_y_pixel=0 and o_x_pixel=0.
- With VGA_TIMING_FRAME_CNT_EN, run 3 frames -> o_frame_count reads 1, 2, 3, each step on the o_frame_start cycle.
